xc_malu_issue: RTL

- Issue sequencer that sits between the XCrypto decode/execute stage and `xc_malu`.
- Accepts one decoded multi-cycle arithmetic request over a valid/ready handshake and latches its operands.
- Drives the `xc_malu` uop, packed-width and valid lines stable until the MALU signals ready.
- Captures the 64-bit result, pulses flush, and returns the result over a response handshake, with watchdog and abort handling.

---
 rtl/xc_malu_issue_if.sv | 26 ++
 rtl/xc_malu_issue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/xc_malu_issue_if.sv
// Request/response handshake between the XCrypto decode/execute stage and xc_malu_issue.
// The decode stage takes the master modport; the issue sequencer takes the slave modport.
interface xc_malu_issue_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [2:0]  req_pw;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [31:0] req_rs3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_error;
  logic        abort;

  modport master (
    output req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3, rsp_ready, abort,
    input  req_ready, rsp_valid, rsp_result, rsp_error
  );

  modport slave (
    input  req_valid, req_op, req_pw, req_rs1, req_rs2, req_rs3, rsp_ready, abort,
    output req_ready, rsp_valid, rsp_result, rsp_error
  );
endinterface

// File: rtl/xc_malu_issue.sv
// Issue sequencer between XCrypto decode/execute and xc_malu: latches one request, holds the
// MALU lines until ready or watchdog expiry, then returns the result. Optional: XC_MALU_ISSUE_DIV0_BYPASS_EN.
module xc_malu_issue #(
  parameter int MAX_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  xc_malu_issue_if.slave      bus,
  output logic [31:0]         malu_rs1,
  output logic [31:0]         malu_rs2,
  output logic [31:0]         malu_rs3,
  output logic                malu_valid,
  output logic                malu_uop_div,
  output logic                malu_uop_divu,
  output logic                malu_uop_rem,
  output logic                malu_uop_remu,
  output logic                malu_uop_mul,
  output logic                malu_uop_mulu,
  output logic                malu_uop_mulsu,
  output logic                malu_uop_clmul,
  output logic                malu_uop_pmul,
  output logic                malu_uop_pclmul,
  output logic                malu_uop_madd,
  output logic                malu_uop_msub,
  output logic                malu_uop_macc,
  output logic                malu_uop_mmul,
  output logic                malu_pw_32,
  output logic                malu_pw_16,
  output logic                malu_pw_8,
  output logic                malu_pw_4,
  output logic                malu_pw_2,
  output logic                malu_flush,
  output logic [31:0]         malu_flush_data,
  input  logic [63:0]         malu_result,
  input  logic                malu_ready
);

  localparam int              CW       = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t         state;
  logic [13:0]    uop_q;
  logic [4:0]     pw_q;
  logic [CW-1:0]  cycle_cnt;
  logic           req_ready_q;
  logic           rsp_valid_q;
  logic           rsp_error_q;
  logic [63:0]    rsp_result_q;

  logic           accept;
  logic           req_packed;
  logic           req_illegal;
  logic           div0_bypass;
  logic [63:0]    div0_result;
  logic [13:0]    uop_dec;
  logic [4:0]     pw_dec;
  logic           watchdog_hit;
  logic           issue_exit;

  assign accept     = bus.req_valid && req_ready_q;
  assign req_packed = (bus.req_op == 4'd8) || (bus.req_op == 4'd9);

  // Only pmul/pclmul take a sub-word width; everything else must be a plain 32-bit op.
  assign req_illegal = (bus.req_op > 4'd13) || (bus.req_pw > 3'd4) ||
                       (req_packed ? (bus.req_pw == 3'd0) : (bus.req_pw != 3'd0));

`ifdef XC_MALU_ISSUE_DIV0_BYPASS_EN
  // Division by zero is answered locally with the RISC-V defined results.
  assign div0_bypass = (bus.req_op < 4'd4) && (bus.req_rs2 == 32'd0);
  assign div0_result = bus.req_op[1] ? {32'd0, bus.req_rs1} : 64'h0000_0000_FFFF_FFFF;
`else
  assign div0_bypass = 1'b0;
  assign div0_result = 64'd0;
`endif

  assign uop_dec = 14'd1 << bus.req_op;
  assign pw_dec  = 5'd1 << bus.req_pw;

  assign watchdog_hit = (cycle_cnt == CNT_LAST);
  assign issue_exit   = bus.abort || malu_ready || watchdog_hit;

  // Flush is combinational so the MALU sees it in the same cycle it hands back ready.
  assign malu_flush      = malu_valid && issue_exit;
  assign malu_flush_data = 32'd0;

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_error  = rsp_error_q;
  assign bus.rsp_result = rsp_result_q;

  assign {malu_uop_mmul, malu_uop_macc, malu_uop_msub, malu_uop_madd,
          malu_uop_pclmul, malu_uop_pmul, malu_uop_clmul, malu_uop_mulsu,
          malu_uop_mulu, malu_uop_mul, malu_uop_remu, malu_uop_rem,
          malu_uop_divu, malu_uop_div} = uop_q;

  assign {malu_pw_2, malu_pw_4, malu_pw_8, malu_pw_16, malu_pw_32} = pw_q;

  // NOTE: all state here uses non-blocking assignments so every register samples the
  // pre-edge values; blocking assignments would make later statements see updated values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_result_q <= 64'd0;
      malu_valid   <= 1'b0;
      uop_q        <= '0;
      pw_q         <= '0;
      cycle_cnt    <= '0;
      malu_rs1     <= 32'd0;
      malu_rs2     <= 32'd0;
      malu_rs3     <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            malu_rs1    <= bus.req_rs1;
            malu_rs2    <= bus.req_rs2;
            malu_rs3    <= bus.req_rs3;
            req_ready_q <= 1'b0;
            if (req_illegal) begin
              state        <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_error_q  <= 1'b1;
              rsp_result_q <= 64'd0;
            end else if (div0_bypass) begin
              state        <= S_RESP;
              rsp_valid_q  <= 1'b1;
              rsp_error_q  <= 1'b0;
              rsp_result_q <= div0_result;
            end else begin
              state      <= S_ISSUE;
              malu_valid <= 1'b1;
              uop_q      <= uop_dec;
              pw_q       <= pw_dec;
              cycle_cnt  <= '0;
            end
          end
        end

        S_ISSUE: begin
          cycle_cnt <= cycle_cnt + 1'b1;
          if (issue_exit) begin
            malu_valid <= 1'b0;
            uop_q      <= '0;
            pw_q       <= '0;
          end
          // Abort outranks a simultaneous ready or watchdog expiry.
          if (bus.abort) begin
            state       <= S_IDLE;
            req_ready_q <= 1'b1;
          end else if (malu_ready) begin
            state        <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_error_q  <= 1'b0;
            rsp_result_q <= malu_result;
          end else if (watchdog_hit) begin
            state        <= S_RESP;
            rsp_valid_q  <= 1'b1;
            rsp_error_q  <= 1'b1;
            rsp_result_q <= 64'd0;
          end
        end

        S_RESP: begin
          if (bus.abort || bus.rsp_ready) begin
            state       <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
          malu_valid  <= 1'b0;
          uop_q       <= '0;
          pw_q        <= '0;
        end
      endcase
    end
  end

endmodule
